// File: rtl/guess_round_ctrl.sv
// Round controller for a four-digit ?A?B guessing game: digit entry, comparator handshake, result display.
// Optional GUESS_TIMEOUT_EN forces LOSE after ENTRY_TIMEOUT idle cycles in ENTRY.
module guess_round_ctrl #(
   parameter int unsigned MAX_TRIES     = 8,
   parameter int unsigned RESULT_HOLD   = 50000000,
   parameter int unsigned ENTRY_TIMEOUT = 500000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       check,
   input  logic       digit_valid,
   input  logic [3:0] digit_in,
   input  logic       cmp_done,
   input  logic [3:0] a_count,
   input  logic [3:0] b_count,
   output logic       cmp_req,
   output logic [3:0] guess0,
   output logic [3:0] guess1,
   output logic [3:0] guess2,
   output logic [3:0] guess3,
   output logic       show_result,
   output logic       in_error,
   output logic       win,
   output logic       lose,
   output logic [3:0] tries
);

   typedef enum logic [2:0] {IDLE, ENTRY, COMPARE, RESULT, WIN, LOSE} state_t;

   localparam int unsigned HOLD_W = $clog2(RESULT_HOLD + 1);

   state_t             state_q, state_d;
   logic               start_prev_q, check_prev_q;
   logic [2:0]         count_q, count_d;
   logic [3:0]         guess_q [4];
   logic [3:0]         guess_d [4];
   logic [3:0]         tries_q, tries_d, tries_inc;
   logic               in_error_q, in_error_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [7:0]         result_q, result_d;
   logic               start_ev, check_ev, dup;

   assign start_ev  = start & ~start_prev_q;
   assign check_ev  = check & ~check_prev_q;
   assign tries_inc = (tries_q == 4'hF) ? 4'hF : tries_q + 4'd1;

`ifdef GUESS_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(ENTRY_TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic              timeout_hit;

   assign timeout_hit = (idle_cnt_q == IDLE_W'(ENTRY_TIMEOUT - 1));

   // A restart from ENTRY stays in ENTRY, so the start event must clear the count too
   always_comb begin
      idle_cnt_d = idle_cnt_q + 1'b1;
      if (state_q != ENTRY || start_ev || check_ev) idle_cnt_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) idle_cnt_q <= '0;
      else       idle_cnt_q <= idle_cnt_d;
   end
`else
   logic timeout_hit;
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = (ENTRY_TIMEOUT == 0);
`endif

   // Comparator result kept for observation; the decision uses the live a_count
   logic unused_result;
   assign unused_result = ^result_q;

   always_comb begin
      dup = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if ((count_q > 3'(i)) && (guess_q[i] == digit_in)) dup = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      guess_d    = guess_q;
      tries_d    = tries_q;
      in_error_d = 1'b0;
      hold_cnt_d = hold_cnt_q;
      result_d   = result_q;

      if (start_ev) begin
         state_d = ENTRY;
         count_d = '0;
         guess_d = '{default: '0};
         tries_d = '0;
      end else begin
         case (state_q)
            ENTRY: begin
               if (check_ev) begin
                  if (digit_valid && !dup) begin
                     guess_d[3] = guess_q[2];
                     guess_d[2] = guess_q[1];
                     guess_d[1] = guess_q[0];
                     guess_d[0] = digit_in;
                     count_d    = count_q + 3'd1;
                     if (count_q == 3'd3) state_d = COMPARE;
                  end else begin
                     in_error_d = 1'b1;
                  end
               end else if (timeout_hit) begin
                  state_d = LOSE;
               end
            end
            COMPARE: begin
               if (cmp_done) begin
                  result_d   = {a_count, b_count};
                  tries_d    = tries_inc;
                  hold_cnt_d = '0;
                  if (a_count == 4'd4)                  state_d = WIN;
                  else if (tries_inc == 4'(MAX_TRIES))  state_d = LOSE;
                  else                                  state_d = RESULT;
               end
            end
            RESULT: begin
               if (hold_cnt_q == HOLD_W'(RESULT_HOLD - 1)) begin
                  state_d = ENTRY;
                  count_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         start_prev_q <= start;
         check_prev_q <= check;
         count_q      <= '0;
         guess_q      <= '{default: '0};
         tries_q      <= '0;
         in_error_q   <= 1'b0;
         hold_cnt_q   <= '0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start;
         check_prev_q <= check;
         count_q      <= count_d;
         guess_q      <= guess_d;
         tries_q      <= tries_d;
         in_error_q   <= in_error_d;
         hold_cnt_q   <= hold_cnt_d;
         result_q     <= result_d;
      end
   end

   assign cmp_req     = (state_q == COMPARE);
   assign show_result = (state_q == RESULT) || (state_q == WIN) || (state_q == LOSE);
   assign win         = (state_q == WIN);
   assign lose        = (state_q == LOSE);
   assign in_error    = in_error_q;
   assign tries       = tries_q;
   assign guess0      = guess_q[0];
   assign guess1      = guess_q[1];
   assign guess2      = guess_q[2];
   assign guess3      = guess_q[3];

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Scoreboard bench for guess_round_ctrl: stimulus queues expectations, a negedge monitor pops and compares.
module tb_guess_round_ctrl;

   logic       clock = 1'b0;
   logic       reset, start, check, digit_valid, cmp_done;
   logic [3:0] digit_in, a_count, b_count;
   logic       cmp_req, show_result, in_error, win, lose;
   logic [3:0] guess0, guess1, guess2, guess3, tries;

   guess_round_ctrl #(.MAX_TRIES(3), .RESULT_HOLD(4), .ENTRY_TIMEOUT(20)) dut (
      .clock(clock), .reset(reset), .start(start), .check(check),
      .digit_valid(digit_valid), .digit_in(digit_in), .cmp_done(cmp_done),
      .a_count(a_count), .b_count(b_count), .cmp_req(cmp_req),
      .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
      .show_result(show_result), .in_error(in_error), .win(win), .lose(lose),
      .tries(tries)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cycles;
      logic [15:0] g;
      logic [3:0] t;
      logic [2:0] swl;
   } cmp_exp_t;

   typedef struct {
      string       tag;
      logic [24:0] v;
   } snap_t;

   cmp_exp_t    cmp_q[$];
   logic [15:0] err_q[$];
   int          hold_q[$];
   snap_t       snap_q[$];
   logic [7:0]  resp_q[$];

   int checks = 0;
   int fails  = 0;
   int resp_delay = 3;
   int late_req = 0, late_ack = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void unexpected(input string name);
      checks++;
      fails++;
      $display("FAIL %s: got an output event expected none", name);
   endfunction

   function automatic logic [24:0] pack(input logic req, show, err, w, l,
                                        input logic [3:0] t, input logic [15:0] g);
      return {req, show, err, w, l, t, g};
   endfunction

   // Comparator model: answers on the resp_delay-th cycle of cmp_req, or emits a requested stray pulse
   int req_cnt = 0;
   always @(negedge clock) begin
      logic [7:0] r;
      if (cmp_done) begin
         cmp_done = 1'b0;
         req_cnt  = 0;
      end else if (late_ack != late_req) begin
         late_ack++;
         a_count  = 4'd4;
         b_count  = 4'd0;
         cmp_done = 1'b1;
      end else if (cmp_req) begin
         req_cnt++;
         if (req_cnt == resp_delay && resp_q.size() != 0) begin
            r        = resp_q.pop_front();
            a_count  = r[7:4];
            b_count  = r[3:0];
            cmp_done = 1'b1;
         end
      end else begin
         req_cnt = 0;
      end
   end

   // Monitor
   int       req_cycles = 0;
   logic     prev_req = 1'b0;
   int       run_len = 0;
   cmp_exp_t ce;
   snap_t    se;
   int       he;
   always @(negedge clock) begin
      if (cmp_req) begin
         req_cycles++;
      end else if (prev_req) begin
         if (cmp_q.size() == 0) unexpected("cmp_event");
         else begin
            ce = cmp_q.pop_front();
            chk("cmp_req_cycles", req_cycles, ce.cycles);
            chk("cmp_guesses", {guess3, guess2, guess1, guess0}, ce.g);
            chk("cmp_tries", tries, ce.t);
            chk("cmp_outcome", {show_result, win, lose}, ce.swl);
         end
         req_cycles = 0;
      end
      prev_req = cmp_req;

      if (in_error) begin
         if (err_q.size() == 0) unexpected("in_error");
         else chk("in_error_guesses", {guess3, guess2, guess1, guess0}, err_q.pop_front());
      end

      if (show_result && !win && !lose) begin
         run_len++;
      end else if (run_len != 0) begin
         if (hold_q.size() == 0) unexpected("result_hold");
         else begin
            he = hold_q.pop_front();
            chk("result_hold_len", run_len, he);
         end
         run_len = 0;
      end

      if (snap_q.size() != 0) begin
         se = snap_q.pop_front();
         chk({"snap_", se.tag}, pack(cmp_req, show_result, in_error, win, lose, tries,
                                     {guess3, guess2, guess1, guess0}), se.v);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] d, input logic v);
      digit_in    = d;
      digit_valid = v;
      check       = 1'b1;
      tick(1);
      check       = 1'b0;
      tick(1);
   endtask

   task automatic start_round();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
   endtask

   task automatic snap(input string tag, input logic [24:0] v);
      snap_t s;
      s.tag = tag;
      s.v   = v;
      snap_q.push_back(s);
      tick(1);
   endtask

   task automatic exp_cmp(input int cyc, input logic [15:0] g, input logic [3:0] t, input logic [2:0] swl);
      cmp_exp_t e;
      e.cycles = cyc;
      e.g      = g;
      e.t      = t;
      e.swl    = swl;
      cmp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b0; check = 1'b0; digit_valid = 1'b0;
      digit_in = 4'd0; cmp_done = 1'b0; a_count = 4'd0; b_count = 4'd0;
      tick(2);
      reset = 1'b0;
      snap("reset", '0);

      start_round();
      snap("entry", '0);

      // Win path
      exp_cmp(3, 16'h1234, 4'd1, 3'b110);
      resp_q.push_back(8'h40);
      press(4'd1, 1'b1); press(4'd2, 1'b1); press(4'd3, 1'b1); press(4'd4, 1'b1);
      tick(8);
      snap("win", pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 16'h1234));

      // Rejections, then lose path over three guesses
      start_round();
      snap("restart", '0);
      press(4'd5, 1'b1);
      err_q.push_back(16'h0005);
      press(4'd5, 1'b1);
      err_q.push_back(16'h0005);
      press(4'd12, 1'b0);
      exp_cmp(3, 16'h5678, 4'd1, 3'b100);
      resp_q.push_back(8'h12);
      hold_q.push_back(4);
      press(4'd6, 1'b1); press(4'd7, 1'b1); press(4'd8, 1'b1);
      tick(10);
      exp_cmp(3, 16'h9012, 4'd2, 3'b100);
      resp_q.push_back(8'h12);
      hold_q.push_back(4);
      press(4'd9, 1'b1); press(4'd0, 1'b1); press(4'd1, 1'b1); press(4'd2, 1'b1);
      tick(10);
      exp_cmp(3, 16'h3456, 4'd3, 3'b101);
      resp_q.push_back(8'h12);
      press(4'd3, 1'b1); press(4'd4, 1'b1); press(4'd5, 1'b1); press(4'd6, 1'b1);
      tick(8);
      snap("lose", pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 16'h3456));
      press(4'd7, 1'b1);
      snap("lose_ignores_check", pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 16'h3456));

      // Restart while cmp_req is pending, then a stray cmp_done
      start_round();
      resp_delay = 100;
      exp_cmp(2, 16'h0000, 4'd0, 3'b000);
      press(4'd1, 1'b1); press(4'd2, 1'b1); press(4'd3, 1'b1); press(4'd4, 1'b1);
      start_round();
      late_req++;
      tick(4);
      resp_delay = 3;
      snap("late_done_ignored", '0);

      // Held check gives one digit; a duplicate event would raise in_error
      digit_in = 4'd7; digit_valid = 1'b1; check = 1'b1;
      tick(10);
      check = 1'b0;
      tick(1);
      snap("held_check", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0007));

      digit_in = 4'd8; start = 1'b1; check = 1'b1;
      tick(1);
      start = 1'b0; check = 1'b0;
      tick(1);
      snap("start_beats_check", '0);

`ifdef GUESS_TIMEOUT_EN
      tick(25);
      snap("timeout_lose", pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000));
      press(4'd2, 1'b1);
      snap("timeout_lose_hold", pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000));
`else
      tick(100);
      snap("no_timeout", '0);
      press(4'd2, 1'b1);
      snap("entry_alive", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0002));
`endif

      // Reset in the middle of RESULT
      start_round();
      exp_cmp(3, 16'h1234, 4'd1, 3'b100);
      resp_q.push_back(8'h00);
      hold_q.push_back(1);
      press(4'd1, 1'b1); press(4'd2, 1'b1); press(4'd3, 1'b1); press(4'd4, 1'b1);
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      snap("reset_mid_result", '0);

      tick(3);
      chk("queues_drained", cmp_q.size() + err_q.size() + hold_q.size() + snap_q.size() + resp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
